// File: rtl/tick_to_level_moore_if.sv
// ============================================================================
// tick_to_level_moore_if : request/level bundle for the tick-to-level stretcher
// Rev 1.0
// ============================================================================
`default_nettype none

interface tick_to_level_moore_if;
    logic tick;
    logic retrig_en;
    logic level;
    logic busy;
    logic drop;

    modport master (
        output tick,
        output retrig_en,
        input  level,
        input  busy,
        input  drop
    );

    modport slave (
        input  tick,
        input  retrig_en,
        output level,
        output busy,
        output drop
    );
endinterface

`default_nettype wire

// File: rtl/tick_to_level_moore.sv
// ============================================================================
// tick_to_level_moore : stretches single-cycle ticks into paced level pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_to_level_moore #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    tick_to_level_moore_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_HIGH = 2'b01;
    localparam logic [1:0] S_GAP  = 2'b10;

    localparam logic [CNT_W-1:0] C_HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam bit               C_HAS_GAP   = (GAP_CYCLES > 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             drop_q, drop_d;

    logic w_last;
    logic w_retrig;

    assign w_last   = (cnt_q == '0);
    assign w_retrig = bus.tick & bus.retrig_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    // A queued tick fills the one-deep slot, or is dropped if it is already full.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        drop_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.tick) begin
                    state_d = S_HIGH;
                    cnt_d   = C_HIGH_LOAD;
                end
            end
            S_HIGH: begin
                if (w_retrig) begin
                    cnt_d = C_HIGH_LOAD;
                end else if (!w_last) begin
                    cnt_d     = cnt_q - C_ONE;
                    pending_d = pending_q | bus.tick;
                    drop_d    = pending_q & bus.tick;
                end else if (C_HAS_GAP) begin
                    state_d   = S_GAP;
                    cnt_d     = C_GAP_LOAD;
                    pending_d = pending_q | bus.tick;
                    drop_d    = pending_q & bus.tick;
                end else if (pending_q) begin
                    // Zero gap: back-to-back pulses merge into one continuous level.
                    cnt_d     = C_HIGH_LOAD;
                    pending_d = bus.tick;
                end else if (bus.tick) begin
                    cnt_d = C_HIGH_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (!w_last) begin
                    cnt_d     = cnt_q - C_ONE;
                    pending_d = pending_q | bus.tick;
                    drop_d    = pending_q & bus.tick;
                end else if (pending_q) begin
                    state_d   = S_HIGH;
                    cnt_d     = C_HIGH_LOAD;
                    pending_d = bus.tick;
                end else if (bus.tick) begin
                    state_d = S_HIGH;
                    cnt_d   = C_HIGH_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.level = (state_q == S_HIGH);
        bus.busy  = (state_q == S_HIGH) || (state_q == S_GAP);
        bus.drop  = drop_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_to_level_moore.sv
// ============================================================================
// tb_tick_to_level_moore : directed and random checks against a timing model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tick_to_level_moore;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    tick_to_level_moore_if ifa ();
    tick_to_level_moore_if ifb ();

    tick_to_level_moore #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    tick_to_level_moore #(.HIGH_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Model state: remaining high cycles, remaining gap cycles, queued request.
    int ma_hi, ma_gp, mb_hi, mb_gp;
    bit ma_pend, mb_pend, ma_drop, mb_drop;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ma_hi = 0; ma_gp = 0; ma_pend = 0; ma_drop = 0;
        mb_hi = 0; mb_gp = 0; mb_pend = 0; mb_drop = 0;
    endtask

    task automatic model_step(input int h, input int g, input bit t, input bit re,
                              inout int hi, inout int gp, inout bit pend, output bit drp);
        bit used;
        used = 0;
        drp  = 0;
        if (hi > 0) begin
            if (t && re) begin
                hi   = h;
                used = 1;
            end else begin
                hi--;
                if (hi == 0) begin
                    if (g > 0) gp = g;
                    else if (pend) begin pend = 0; hi = h; end
                    else if (t) begin hi = h; used = 1; end
                end
            end
        end else if (gp > 0) begin
            gp--;
            if (gp == 0) begin
                if (pend) begin pend = 0; hi = h; end
                else if (t) begin hi = h; used = 1; end
            end
        end else if (t) begin
            hi   = h;
            used = 1;
        end
        if (t && !used) begin
            if (pend) drp = 1;
            else      pend = 1;
        end
    endtask

    task automatic step(input bit t0, input bit re0, input bit t1, input bit re1);
        @(negedge clk);
        ifa.tick = t0; ifa.retrig_en = re0;
        ifb.tick = t1; ifb.retrig_en = re1;
        @(posedge clk);
        model_step(4, 2, t0, re0, ma_hi, ma_gp, ma_pend, ma_drop);
        model_step(1, 0, t1, re1, mb_hi, mb_gp, mb_pend, mb_drop);
        #1;
        chk("a_level", ifa.level, ma_hi > 0);
        chk("a_busy",  ifa.busy,  (ma_hi > 0) || (ma_gp > 0));
        chk("a_drop",  ifa.drop,  ma_drop);
        chk("b_level", ifb.level, mb_hi > 0);
        chk("b_busy",  ifb.busy,  (mb_hi > 0) || (mb_gp > 0));
        chk("b_drop",  ifb.drop,  mb_drop);
    endtask

    initial begin
        bit r0, r1;
        ifa.tick = 0; ifa.retrig_en = 0;
        ifb.tick = 0; ifb.retrig_en = 0;
        model_reset();

        @(posedge clk); #1;
        chk("rst_a_level", ifa.level, 1'b0);
        chk("rst_a_busy",  ifa.busy,  1'b0);
        chk("rst_a_drop",  ifa.drop,  1'b0);
        chk("rst_b_busy",  ifb.busy,  1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Single tick: 4 high, 2 gap, then idle.
        for (int k = 0; k < 10; k++) begin
            step(k == 0, 0, 0, 0);
            chk("s1_level", ifa.level, k < 4);
            chk("s1_busy",  ifa.busy,  k < 6);
            chk("s1_drop",  ifa.drop,  1'b0);
        end

        // Second tick queued during high: fires after exactly two low cycles.
        for (int k = 0; k < 13; k++) begin
            step((k == 0) || (k == 2), 0, 0, 0);
            chk("s2_level", ifa.level, (k < 4) || (k >= 6 && k < 10));
        end

        // Overflowing ticks are dropped; only two pulses.
        for (int k = 0; k < 14; k++) begin
            step((k == 0) || (k == 1) || (k == 2) || (k == 5), 0, 0, 0);
            chk("s3_drop",  ifa.drop,  (k == 2) || (k == 5));
            chk("s3_level", ifa.level, (k < 4) || (k >= 6 && k < 10));
        end

        // Retrigger keeps the window open without queueing.
        for (int k = 0; k < 14; k++) begin
            step((k == 0) || (k == 3) || (k == 6), 1, 0, 0);
            chk("s4_level", ifa.level, k < 10);
            chk("s4_busy",  ifa.busy,  k < 12);
            chk("s4_drop",  ifa.drop,  1'b0);
        end

        // Zero gap, one-cycle pulses: a held tick merges into one level.
        for (int k = 0; k < 6; k++) begin
            step(0, 0, k < 3, 0);
            chk("s6_level", ifb.level, k < 3);
            chk("s6_busy",  ifb.busy,  k < 3);
            chk("s6_drop",  ifb.drop,  1'b0);
        end

        // Asynchronous reset in the middle of a pulse with a request queued.
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        chk("s5_level", ifa.level, 1'b0);
        chk("s5_busy",  ifa.busy,  1'b0);
        chk("s5_drop",  ifa.drop,  1'b0);
        chk("s5_b_busy", ifb.busy, 1'b0);
        model_reset();
        @(negedge clk);
        ifa.tick = 0; ifb.tick = 0;
        @(posedge clk); #1;
        chk("s5_hold_busy", ifa.busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0);
            chk("s5_after_level", ifa.level, 1'b0);
        end

        // Random traffic against the model on both configurations.
        r0 = 0; r1 = 0;
        for (int i = 0; i < 800; i++) begin
            if (i % 16 == 0) begin
                r0 = 1'($urandom_range(0, 1));
                r1 = 1'($urandom_range(0, 1));
            end
            step($urandom_range(0, 2) == 0, r0, $urandom_range(0, 1) == 0, r1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
